// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the two-port memory arbiter.
// Optional statistics counters are enabled with MEM_ARB_STATS_EN.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        TAG_NONE = 2'd0,
        TAG_P0   = 2'd1,
        TAG_P1   = 2'd2
    } tag_t;

    localparam int PORT0 = 0;
    localparam int PORT1 = 1;
    localparam int CNT_W = 32;

endpackage

// File: rtl/mem_arb_stats.sv
// Grant, conflict and wait counters for mem_port_arbiter.
// Instantiated only when MEM_ARB_STATS_EN is defined.
module mem_arb_stats
    import mem_arb_pkg::*;
#(
    parameter int CORE = 0
) (
    input  logic clock,
    input  logic reset,
    input  logic req0,
    input  logic req1,
    input  logic grant0,
    input  logic grant1,
    input  logic report
);

    logic [CNT_W-1:0] grants0;
    logic [CNT_W-1:0] grants1;
    logic [CNT_W-1:0] conflicts;
    logic [CNT_W-1:0] wait0;
    logic [CNT_W-1:0] wait1;

    always_ff @(posedge clock) begin
        if (reset) begin
            grants0   <= '0;
            grants1   <= '0;
            conflicts <= '0;
            wait0     <= '0;
            wait1     <= '0;
        end else begin
            if (grant0)
                grants0 <= grants0 + 1'b1;
            if (grant1)
                grants1 <= grants1 + 1'b1;
            if (req0 && req1)
                conflicts <= conflicts + 1'b1;
            if (req0 && !grant0)
                wait0 <= wait0 + 1'b1;
            if (req1 && !grant1)
                wait1 <= wait1 + 1'b1;
        end
    end

`ifndef SYNTHESIS
    always_ff @(posedge clock) begin
        if (report)
            $display("core %0d arb stats: g0=%0d g1=%0d conf=%0d w0=%0d w1=%0d",
                     CORE, grants0, grants1, conflicts, wait0, wait1);
    end
`endif

endmodule

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter with requester lock sharing one BRAM port.
// Define MEM_ARB_STATS_EN to add grant/conflict/wait counters.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int CORE         = 0,
    parameter int DATA_WIDTH   = 32,
    parameter int ADDRESS_BITS = 11
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    r0_read,
    input  logic                    r0_write,
    input  logic [ADDRESS_BITS-1:0] r0_address,
    input  logic [DATA_WIDTH-1:0]   r0_in_data,
    input  logic                    r0_lock,
    output logic                    r0_grant,
    output logic                    r0_valid,
    output logic [DATA_WIDTH-1:0]   r0_out_data,
    input  logic                    r1_read,
    input  logic                    r1_write,
    input  logic [ADDRESS_BITS-1:0] r1_address,
    input  logic [DATA_WIDTH-1:0]   r1_in_data,
    input  logic                    r1_lock,
    output logic                    r1_grant,
    output logic                    r1_valid,
    output logic [DATA_WIDTH-1:0]   r1_out_data,
    output logic                    mem_read,
    output logic                    mem_write,
    output logic [ADDRESS_BITS-1:0] mem_address,
    output logic [DATA_WIDTH-1:0]   mem_in_data,
    input  logic                    mem_valid,
    input  logic [DATA_WIDTH-1:0]   mem_out_data,
    input  logic                    report
);

    logic req0;
    logic req1;
    logic lock_hold;
    logic last_grant;
    logic lock_active;
    logic lock_owner;
    tag_t tag;

    assign req0 = r0_read | r0_write;
    assign req1 = r1_read | r1_write;

    // An idle owner releases the lock within the same cycle.
    assign lock_hold = lock_active & (lock_owner ? req1 : req0);

    always_comb begin
        r0_grant = 1'b0;
        r1_grant = 1'b0;
        if (reset) begin
            r0_grant = 1'b0;
            r1_grant = 1'b0;
        end else if (lock_hold) begin
            r0_grant = ~lock_owner;
            r1_grant = lock_owner;
        end else if (req0 && req1) begin
            r0_grant = last_grant;
            r1_grant = ~last_grant;
        end else begin
            r0_grant = req0;
            r1_grant = req1;
        end
    end

    always_comb begin
        mem_read    = 1'b0;
        mem_write   = 1'b0;
        mem_address = '0;
        mem_in_data = '0;
        if (r0_grant) begin
            mem_read    = r0_read & ~r0_write;
            mem_write   = r0_write;
            mem_address = r0_address;
            mem_in_data = r0_in_data;
        end else if (r1_grant) begin
            mem_read    = r1_read & ~r1_write;
            mem_write   = r1_write;
            mem_address = r1_address;
            mem_in_data = r1_in_data;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            last_grant  <= 1'b1;
            lock_active <= 1'b0;
            lock_owner  <= 1'b0;
            tag         <= TAG_NONE;
        end else begin
            if (r0_grant)
                tag <= TAG_P0;
            else if (r1_grant)
                tag <= TAG_P1;
            else
                tag <= TAG_NONE;
            if (r0_grant || r1_grant) begin
                last_grant <= r1_grant;
                lock_owner <= r1_grant;
            end
            lock_active <= (r0_grant & r0_lock) | (r1_grant & r1_lock);
        end
    end

    assign r0_valid    = mem_valid & (tag == TAG_P0) & ~reset;
    assign r1_valid    = mem_valid & (tag == TAG_P1) & ~reset;
    assign r0_out_data = mem_out_data;
    assign r1_out_data = mem_out_data;

`ifdef MEM_ARB_STATS_EN
    mem_arb_stats #(
        .CORE (CORE)
    ) u_stats (
        .clock  (clock),
        .reset  (reset),
        .req0   (req0),
        .req1   (req1),
        .grant0 (r0_grant),
        .grant1 (r1_grant),
        .report (report)
    );
`endif

`ifndef SYNTHESIS
    always_ff @(posedge clock) begin
        if (report)
            $display("core %0d arb: g0=%b g1=%b tag=%0d lock=%b owner=%0d",
                     CORE, r0_grant, r1_grant, tag, lock_active, lock_owner);
    end
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter with a registered BRAM stub.
// Counter checks run only when MEM_ARB_STATS_EN is defined.
module tb_mem_port_arbiter;

    localparam int DW = 32;
    localparam int AW = 11;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic          r0_read = 1'b0;
    logic          r0_write = 1'b0;
    logic [AW-1:0] r0_address = '0;
    logic [DW-1:0] r0_in_data = '0;
    logic          r0_lock = 1'b0;
    logic          r0_grant;
    logic          r0_valid;
    logic [DW-1:0] r0_out_data;
    logic          r1_read = 1'b0;
    logic          r1_write = 1'b0;
    logic [AW-1:0] r1_address = '0;
    logic [DW-1:0] r1_in_data = '0;
    logic          r1_lock = 1'b0;
    logic          r1_grant;
    logic          r1_valid;
    logic [DW-1:0] r1_out_data;
    logic          mem_read;
    logic          mem_write;
    logic [AW-1:0] mem_address;
    logic [DW-1:0] mem_in_data;
    logic          mem_valid = 1'b0;
    logic [DW-1:0] mem_out_data = '0;
    logic          report = 1'b0;

    mem_port_arbiter #(
        .CORE         (0),
        .DATA_WIDTH   (DW),
        .ADDRESS_BITS (AW)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .r0_read      (r0_read),
        .r0_write     (r0_write),
        .r0_address   (r0_address),
        .r0_in_data   (r0_in_data),
        .r0_lock      (r0_lock),
        .r0_grant     (r0_grant),
        .r0_valid     (r0_valid),
        .r0_out_data  (r0_out_data),
        .r1_read      (r1_read),
        .r1_write     (r1_write),
        .r1_address   (r1_address),
        .r1_in_data   (r1_in_data),
        .r1_lock      (r1_lock),
        .r1_grant     (r1_grant),
        .r1_valid     (r1_valid),
        .r1_out_data  (r1_out_data),
        .mem_read     (mem_read),
        .mem_write    (mem_write),
        .mem_address  (mem_address),
        .mem_in_data  (mem_in_data),
        .mem_valid    (mem_valid),
        .mem_out_data (mem_out_data),
        .report       (report)
    );

    always #5 clock = ~clock;

    function automatic logic [DW-1:0] init_val(input int a);
        return 32'hA500_0000 + 32'(a * 7);
    endfunction

    // BRAM stub: registered valid, never reset, so reset gating is visible.
    logic [DW-1:0] mem [2048];
    bit            mem_wr [2048];

    always @(posedge clock) begin
        mem_valid <= mem_read | mem_write;
        if (mem_write) begin
            mem[mem_address]    <= mem_in_data;
            mem_wr[mem_address] <= 1'b1;
        end else if (mem_read) begin
            mem_out_data <= mem_wr[mem_address] ? mem[mem_address]
                                                : init_val(int'(mem_address));
        end
    end

    typedef struct {
        int            cyc;
        int            port;
        bit            is_read;
        logic [DW-1:0] data;
    } exp_t;

    exp_t          sb [$];
    logic [DW-1:0] ref_mem [int];
    int            n_checks = 0;
    int            n_fail = 0;
    int            cyc = 0;

    always @(posedge clock) cyc <= cyc + 1;

    function automatic logic [DW-1:0] ref_rd(input int a);
        return ref_mem.exists(a) ? ref_mem[a] : init_val(a);
    endfunction

    task automatic push_exp(input int port);
        exp_t e;
        e.cyc  = cyc + 1;
        e.port = port;
        e.data = '0;
        if (port == 0) begin
            e.is_read = !r0_write;
            if (r0_write) ref_mem[int'(r0_address)] = r0_in_data;
            else e.data = ref_rd(int'(r0_address));
        end else begin
            e.is_read = !r1_write;
            if (r1_write) ref_mem[int'(r1_address)] = r1_in_data;
            else e.data = ref_rd(int'(r1_address));
        end
        sb.push_back(e);
    endtask

    exp_t          m_e;
    logic          m_v0;
    logic          m_v1;
    bit            m_rd;
    logic [DW-1:0] m_d;

    always @(negedge clock) begin
        m_v0 = 1'b0;
        m_v1 = 1'b0;
        m_rd = 1'b0;
        m_d  = '0;
        if (sb.size() > 0 && sb[0].cyc == cyc) begin
            m_e  = sb.pop_front();
            m_v0 = (m_e.port == 0);
            m_v1 = (m_e.port == 1);
            m_rd = m_e.is_read;
            m_d  = m_e.data;
        end
        n_checks++;
        if ({r0_valid, r1_valid} !== {m_v0, m_v1}) begin
            n_fail++;
            $display("FAIL resp_valid cyc %0d: got %b%b want %b%b",
                     cyc, r0_valid, r1_valid, m_v0, m_v1);
        end
        if (m_rd) begin
            n_checks++;
            if (r0_out_data !== m_d || r1_out_data !== m_d) begin
                n_fail++;
                $display("FAIL resp_data cyc %0d: got %h/%h want %h",
                         cyc, r0_out_data, r1_out_data, m_d);
            end
        end
    end

    task automatic idle_inputs();
        r0_read = 1'b0; r0_write = 1'b0; r0_lock = 1'b0;
        r1_read = 1'b0; r1_write = 1'b0; r1_lock = 1'b0;
        r0_address = '0; r1_address = '0;
        r0_in_data = '0; r1_in_data = '0;
    endtask

    task automatic apply_reset();
        idle_inputs();
        @(posedge clock); #1;
        reset = 1'b1;
        repeat (2) @(posedge clock);
        #1 reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        r0_read = 1'b1;
        r1_write = 1'b1;
        @(negedge clock);
        n_checks++;
        if ({r0_grant, r1_grant, mem_read, mem_write} !== 4'b0000) begin
            n_fail++;
            $display("FAIL reset_outputs: got %b%b%b%b want 0000",
                     r0_grant, r1_grant, mem_read, mem_write);
        end
        @(posedge clock); #1;
        idle_inputs();
        @(posedge clock); #1;
        reset = 1'b0;
        @(negedge clock);
        n_checks++;
        if ({r0_grant, r1_grant, mem_read, mem_write} !== 4'b0000 ||
            mem_address !== '0) begin
            n_fail++;
            $display("FAIL idle_outputs: got %b%b%b%b addr %h want 0000 addr 0",
                     r0_grant, r1_grant, mem_read, mem_write, mem_address);
        end
        @(posedge clock); #1;
    endtask

    task automatic test_single_read();
        r0_read = 1'b1;
        r0_address = 11'h010;
        @(negedge clock);
        n_checks++;
        if ({r0_grant, r1_grant, mem_read, mem_write} !== 4'b1010 ||
            mem_address !== 11'h010) begin
            n_fail++;
            $display("FAIL single_grant: got %b%b%b%b addr %h want 1010 addr 010",
                     r0_grant, r1_grant, mem_read, mem_write, mem_address);
        end
        push_exp(0);
        @(posedge clock); #1;
        idle_inputs();
        report = 1'b1;
        @(posedge clock); #1;
        report = 1'b0;
    endtask

    task automatic test_alternate();
        int exp_p;
        apply_reset();
        r0_read = 1'b1; r0_address = 11'h004;
        r1_read = 1'b1; r1_address = 11'h200;
        exp_p = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clock);
            n_checks++;
            if (r0_grant !== (exp_p == 0) || r1_grant !== (exp_p == 1)) begin
                n_fail++;
                $display("FAIL alternate_grant %0d: got %b%b want port %0d",
                         i, r0_grant, r1_grant, exp_p);
            end
            n_checks++;
            if (mem_address !== (exp_p == 0 ? 11'h004 : 11'h200)) begin
                n_fail++;
                $display("FAIL alternate_addr %0d: got %h want port %0d addr",
                         i, mem_address, exp_p);
            end
            push_exp(exp_p);
            exp_p = 1 - exp_p;
            @(posedge clock); #1;
        end
        idle_inputs();
    endtask

    task automatic test_lock();
        apply_reset();
        r0_read = 1'b1; r0_address = 11'h300;
        for (int k = -1; k < 4; k++) begin
            if (k >= 0 && k < 3) begin
                r1_write = 1'b1; r1_lock = 1'b1;
                r1_address = 11'(11'h100 + k);
                r1_in_data = 32'h1111_0000 + 32'(k);
            end else if (k == 3) begin
                r1_write = 1'b0; r1_lock = 1'b0;
            end
            @(negedge clock);
            n_checks++;
            if ({r0_grant, r1_grant} !== ((k >= 0 && k < 3) ? 2'b01 : 2'b10)) begin
                n_fail++;
                $display("FAIL lock_grant step %0d: got %b%b", k, r0_grant, r1_grant);
            end
            push_exp((k >= 0 && k < 3) ? 1 : 0);
            @(posedge clock); #1;
        end
        for (int k = 0; k < 3; k++) begin
            r0_address = 11'(11'h100 + k);
            @(negedge clock);
            n_checks++;
            if ({r0_grant, r1_grant} !== 2'b10) begin
                n_fail++;
                $display("FAIL lock_readback_grant %0d: got %b%b want 10",
                         k, r0_grant, r1_grant);
            end
            push_exp(0);
            @(posedge clock); #1;
        end
        idle_inputs();
    endtask

    task automatic test_read_write_both();
        r0_read = 1'b1; r0_write = 1'b1;
        r0_address = 11'h020; r0_in_data = 32'hDEAD_BEEF;
        @(negedge clock);
        n_checks++;
        if ({r0_grant, mem_write, mem_read} !== 3'b110 ||
            mem_in_data !== 32'hDEAD_BEEF) begin
            n_fail++;
            $display("FAIL rw_as_write: got g%b w%b r%b d %h want g1 w1 r0 d deadbeef",
                     r0_grant, mem_write, mem_read, mem_in_data);
        end
        push_exp(0);
        @(posedge clock); #1;
        r0_write = 1'b0;
        @(negedge clock);
        n_checks++;
        if (r0_grant !== 1'b1 || mem_read !== 1'b1) begin
            n_fail++;
            $display("FAIL rw_readback_grant: got g%b r%b want g1 r1", r0_grant, mem_read);
        end
        push_exp(0);
        @(posedge clock); #1;
        idle_inputs();
    endtask

    task automatic test_reset_mid();
        apply_reset();
        r0_read = 1'b1; r0_address = 11'h010;
        @(negedge clock);
        n_checks++;
        if (r0_grant !== 1'b1) begin
            n_fail++;
            $display("FAIL midreset_grant: got %b want 1", r0_grant);
        end
        @(posedge clock); #1;
        idle_inputs();
        reset = 1'b1;
        @(negedge clock);
        n_checks++;
        if ({r0_grant, r1_grant} !== 2'b00) begin
            n_fail++;
            $display("FAIL midreset_grants: got %b%b want 00", r0_grant, r1_grant);
        end
        @(posedge clock); #1;
        reset = 1'b0;
        @(posedge clock); #1;
        r0_read = 1'b1; r0_address = 11'h040;
        r1_read = 1'b1; r1_address = 11'h041;
        @(negedge clock);
        n_checks++;
        if ({r0_grant, r1_grant} !== 2'b10) begin
            n_fail++;
            $display("FAIL post_reset_conflict: got %b%b want 10", r0_grant, r1_grant);
        end
        push_exp(0);
        @(posedge clock); #1;
        idle_inputs();
    endtask

`ifdef MEM_ARB_STATS_EN
    task automatic test_stats();
        int exp_p;
        apply_reset();
        r0_read = 1'b1; r0_address = 11'h004;
        r1_read = 1'b1; r1_address = 11'h200;
        exp_p = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clock);
            push_exp(exp_p);
            exp_p = 1 - exp_p;
            @(posedge clock); #1;
        end
        idle_inputs();
        n_checks++;
        if (dut.u_stats.conflicts !== 32'd10 || dut.u_stats.grants0 !== 32'd5 ||
            dut.u_stats.grants1 !== 32'd5 || dut.u_stats.wait0 !== 32'd5 ||
            dut.u_stats.wait1 !== 32'd5) begin
            n_fail++;
            $display("FAIL stats: got c%0d g%0d/%0d w%0d/%0d want c10 g5/5 w5/5",
                     dut.u_stats.conflicts, dut.u_stats.grants0, dut.u_stats.grants1,
                     dut.u_stats.wait0, dut.u_stats.wait1);
        end
        report = 1'b1;
        @(posedge clock); #1;
        report = 1'b0;
    endtask
`endif

    initial begin
        test_reset();
        test_single_read();
        test_alternate();
        test_lock();
        test_read_write_both();
        test_reset_mid();
`ifdef MEM_ARB_STATS_EN
        test_stats();
`endif
        repeat (3) @(posedge clock);
        #1;
        n_checks++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: got %0d pending want 0", sb.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Two-port arbiter that shares one single-port BRAM-backed memory interface between an instruction-fetch requester (port 0) and a data/loader requester (port 1). It grants at most one access per cycle using round-robin with optional requester lock. It drives the memory interface's read/write/address/data inputs and routes that interface's registered `valid` and read data back to the requester that issued the access. It sits between the core front-end/LSU and the memory interface instance of one core.

## Interface
- `CORE`, 0, core index printed in reports
- `DATA_WIDTH`, 32, data word width
- `ADDRESS_BITS`, 11, word address width
- `clock`  in  1  system clock
- `reset`  in  1  reset, synchronous, active-high
- `rN_read`, `rN_write`  in  1 each  (N = 0, 1) access request; held until granted
- `rN_address`  in  ADDRESS_BITS  request address
- `rN_in_data`  in  DATA_WIDTH  write data
- `rN_lock`  in  1  keep ownership for following cycles
- `rN_grant`  out  1  request accepted this cycle
- `rN_valid`  out  1  response for this port's access
- `rN_out_data`  out  DATA_WIDTH  read data (the memory data, passed through to both ports)
- `mem_read`, `mem_write`  out  1 each  to memory interface
- `mem_address`  out  ADDRESS_BITS
- `mem_in_data`  out  DATA_WIDTH
- `mem_valid`  in  1  registered valid from memory interface
- `mem_out_data`  in  DATA_WIDTH  BRAM read data
- `report`  in  1  print state via `$display`

## Operation
- Request N active = `rN_read | rN_write`. Read and write both high on one port is treated as a write: `mem_read`=0.
- Arbitration is combinational in the request cycle:
  - One port requesting: that port is granted.
  - Both ports requesting: the port not in `last_grant` is granted.
  - While `lock_active`: only `lock_owner` can be granted; the other port waits.
- Mux: the granted port's address, data and read/write are driven to `mem_*`. With no grant, `mem_read`=`mem_write`=0 and `mem_address`=0.
- State registers:
  - `last_grant` (1 bit): reset value 1, so port 0 wins the first conflict.
  - `lock_active`, `lock_owner`.
  - `tag` (2 bits: NONE/P0/P1): the port granted last cycle.
- Lock:
  - Set when the granted port has `rN_lock`=1.
  - Cleared in a cycle where the owner is granted with `rN_lock`=0, or the owner does not request.
  - A lock clearing because the owner is idle allows the other port to be granted in that same cycle.
- Response: `rN_valid` = `mem_valid & (tag==PN)`, for both reads and writes. `rN_out_data` = `mem_out_data`.

## Timing
- Grant latency: 0 cycles, combinational from the request.
- Response latency: valid and data appear 1 cycle after the grant.
- Back-to-back grants to the same port are allowed every cycle (full throughput).
- The losing requester stalls ≥1 cycle. Worst-case wait without lock is 1 cycle.
- Reset values:
  - All grants 0, valids 0, `mem_read`/`mem_write` 0.
  - `tag`=NONE, `lock_active`=0, `last_grant`=1.
- Reset mid-access: the in-flight response is dropped (no `rN_valid`).
- `mem_valid` with `tag`=NONE: ignored.

## Configuration
- `MEM_ARB_STATS_EN` defined: 32-bit counters, cleared by reset:
  - `grants0`, `grants1`.
  - `conflicts`: cycles with both ports requesting.
  - `wait0`, `wait1`: cycles requesting but not granted.
  - All counters are printed when `report`=1.
- `MEM_ARB_STATS_EN` undefined: no counters, no counter logic. `report` prints only grants, tag and lock state. Arbitration behaviour is identical in both builds.

## Structure
- Package `mem_arb_pkg`:
  - Tag encoding: `TAG_NONE`=0, `TAG_P0`=1, `TAG_P1`=2.
  - Port index constants.
  - Counter width constant (32).
- Sub-module `mem_arb_stats`: holds the counters. Instantiated only under `MEM_ARB_STATS_EN`.

## Test plan
- Port 0 reads addr 0x010 alone → `r0_grant`=1 same cycle; next cycle `r0_valid`=1 with BRAM word at 0x010; `r1_valid` stays 0.
- Both ports read every cycle after reset (0x004, 0x200) → grants alternate P0,P1,P0,P1; each valid is tagged to the correct port with correct data.
- Port 1 holds `r1_lock`=1 for 3 writes (0x100..0x102) while port 0 requests → port 0 waits 3 cycles; granted the cycle `r1_lock` drops; reads back the written values.
- Port 0 asserts read+write together at 0x020 with data 0xDEADBEEF → `mem_write`=1, `mem_read`=0; a later read of 0x020 returns 0xDEADBEEF.
- Reset asserted the cycle after a grant → no `rN_valid`; state returns to reset values; the next conflict is won by port 0.
- With `MEM_ARB_STATS_EN`: 10 cycles of both ports requesting → `conflicts`=10, `grants0`=5, `grants1`=5, `wait0`=5, `wait1`=5.
